// File: rtl/circuito_jogo_param_if.sv
// Player-side and debug signals of the parametrised memory game engine.
interface circuito_jogo_param_if #(
  parameter int unsigned N_CHAVES = 4
);
  logic                iniciar;
  logic [N_CHAVES-1:0] chaves;
  logic                ganhou;
  logic                perdeu;
  logic                pronto;
  logic [N_CHAVES-1:0] leds;
  logic [3:0]          db_estado;
  logic [7:0]          db_rodada;
  logic [7:0]          db_endereco;
  logic [N_CHAVES-1:0] db_jogada;
  logic                db_jogada_correta;
  logic                db_timeout;

  modport master (
    output iniciar, chaves,
    input  ganhou, perdeu, pronto, leds, db_estado, db_rodada, db_endereco,
           db_jogada, db_jogada_correta, db_timeout
  );

  modport slave (
    input  iniciar, chaves,
    output ganhou, perdeu, pronto, leds, db_estado, db_rodada, db_endereco,
           db_jogada, db_jogada_correta, db_timeout
  );
endinterface

// File: rtl/circuito_jogo_param.sv
// Memory game engine: LFSR sequence, show phase on leds, replay checking.
// Optional per-jogada timeout loss is enabled by defining JOGO_TIMEOUT_EN.
module circuito_jogo_param #(
  parameter int unsigned N_CHAVES       = 4,
  parameter int unsigned N_RODADAS      = 16,
  parameter int unsigned MOSTRA_CICLOS  = 1000,
  parameter int unsigned TIMEOUT_CICLOS = 3000,
  parameter logic [15:0] SEMENTE        = 16'hACE1
) (
  input logic                   clock,
  input logic                   reset,
  circuito_jogo_param_if.slave  jogo
);

  localparam int unsigned SEL_W    = (N_CHAVES > 2) ? $clog2(N_CHAVES) : 1;
  localparam int unsigned MOSTRA_W = (MOSTRA_CICLOS > 1) ? $clog2(MOSTRA_CICLOS) : 1;
  localparam logic [15:0] TAPS     = 16'hB400;
  localparam logic [7:0]  ULTIMA   = 8'(N_RODADAS - 1);
  localparam logic [MOSTRA_W-1:0] MOSTRA_FIM = MOSTRA_W'(MOSTRA_CICLOS - 1);

  // Elaboration-time parameter legality checks
  if (TIMEOUT_CICLOS < 2) begin : g_tmo_invalido
    $error("TIMEOUT_CICLOS must be at least 2");
  end
  if (SEMENTE == 16'h0000) begin : g_semente_invalida
    $error("SEMENTE must be nonzero");
  end

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    MOSTRA      = 4'h2,
    INTERVALO   = 4'h3,
    ESPERA      = 4'h4,
    REGISTRA    = 4'h5,
    COMPARA     = 4'h6,
    PROX_JOGADA = 4'h7,
    PROX_RODADA = 4'h8,
    FIM_GANHOU  = 4'hA,
    FIM_PERDEU  = 4'hB,
    FIM_TIMEOUT = 4'hC
  } estado_t;

  estado_t             estado;
  logic [15:0]         lfsr;
  logic [15:0]         lfsr_prox;
  logic [N_CHAVES-1:0] simbolo;
  logic [N_CHAVES-1:0] simbolo_prox;
  logic [N_CHAVES-1:0] chaves_ant;
  logic                jogada_c;
  logic [MOSTRA_W-1:0] cnt;
  logic [7:0]          rodada;
  logic [7:0]          endereco;
  logic                ganhou;
  logic                perdeu;
  logic                pronto;
  logic [N_CHAVES-1:0] leds;
  logic [N_CHAVES-1:0] jogada;
  logic                jogada_correta;
  logic                fim_timeout;

`ifdef JOGO_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CICLOS);
  localparam logic [TMO_W-1:0] TMO_FIM = TMO_W'(TIMEOUT_CICLOS - 1);
  logic [TMO_W-1:0] timer;
`endif

  function automatic logic [N_CHAVES-1:0] one_hot(input logic [15:0] l);
    return N_CHAVES'(1) << l[SEL_W-1:0];
  endfunction

  // Sequence generator helpers and rising-edge jogada detection
  always_comb begin
    lfsr_prox    = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 16'h0000);
    simbolo      = one_hot(lfsr);
    simbolo_prox = one_hot(lfsr_prox);
    jogada_c     = (jogo.chaves != '0) && (chaves_ant == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado         <= INICIAL;
      lfsr           <= SEMENTE;
      chaves_ant     <= '0;
      cnt            <= '0;
      rodada         <= '0;
      endereco       <= '0;
      ganhou         <= 1'b0;
      perdeu         <= 1'b0;
      pronto         <= 1'b0;
      leds           <= '0;
      jogada         <= '0;
      jogada_correta <= 1'b0;
      fim_timeout    <= 1'b0;
`ifdef JOGO_TIMEOUT_EN
      timer          <= '0;
`endif
    end else begin
      chaves_ant <= jogo.chaves;
      case (estado)
        INICIAL: if (jogo.iniciar) estado <= PREPARA;
        PREPARA: begin
          rodada         <= '0;
          endereco       <= '0;
          lfsr           <= SEMENTE;
          cnt            <= '0;
          jogada         <= '0;
          jogada_correta <= 1'b0;
          leds           <= one_hot(SEMENTE);
          estado         <= MOSTRA;
        end
        MOSTRA: begin
          if (cnt == MOSTRA_FIM) begin
            cnt    <= '0;
            leds   <= '0;
            estado <= INTERVALO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        INTERVALO: begin
          if (cnt == MOSTRA_FIM) begin
            cnt <= '0;
            if (endereco == rodada) begin
              endereco <= '0;
              lfsr     <= SEMENTE;
`ifdef JOGO_TIMEOUT_EN
              timer    <= '0;
`endif
              estado   <= ESPERA;
            end else begin
              endereco <= endereco + 8'd1;
              lfsr     <= lfsr_prox;
              leds     <= simbolo_prox;
              estado   <= MOSTRA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // A jogada in the same cycle as the last timer tick takes priority
        ESPERA: begin
          if (jogada_c) begin
            estado <= REGISTRA;
`ifdef JOGO_TIMEOUT_EN
          end else if (timer == TMO_FIM) begin
            pronto      <= 1'b1;
            perdeu      <= 1'b1;
            fim_timeout <= 1'b1;
            estado      <= FIM_TIMEOUT;
          end else begin
            timer <= timer + 1'b1;
`endif
          end
        end
        REGISTRA: begin
          jogada         <= jogo.chaves;
          jogada_correta <= (jogo.chaves == simbolo);
`ifdef JOGO_TIMEOUT_EN
          timer          <= '0;
`endif
          estado         <= COMPARA;
        end
        COMPARA: begin
          if (!jogada_correta) begin
            pronto <= 1'b1;
            perdeu <= 1'b1;
            estado <= FIM_PERDEU;
          end else if (endereco != rodada) begin
            estado <= PROX_JOGADA;
          end else if (rodada == ULTIMA) begin
            pronto <= 1'b1;
            ganhou <= 1'b1;
            estado <= FIM_GANHOU;
          end else begin
            estado <= PROX_RODADA;
          end
        end
        PROX_JOGADA: begin
          endereco <= endereco + 8'd1;
          lfsr     <= lfsr_prox;
`ifdef JOGO_TIMEOUT_EN
          timer    <= '0;
`endif
          estado   <= ESPERA;
        end
        PROX_RODADA: begin
          rodada   <= rodada + 8'd1;
          endereco <= '0;
          lfsr     <= SEMENTE;
          cnt      <= '0;
          leds     <= one_hot(SEMENTE);
          estado   <= MOSTRA;
        end
        FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
          if (jogo.iniciar) begin
            ganhou      <= 1'b0;
            perdeu      <= 1'b0;
            pronto      <= 1'b0;
            fim_timeout <= 1'b0;
            estado      <= PREPARA;
          end
        end
        default: begin
          leds   <= '0;
          estado <= INICIAL;
        end
      endcase
    end
  end

  assign jogo.ganhou            = ganhou;
  assign jogo.perdeu            = perdeu;
  assign jogo.pronto            = pronto;
  assign jogo.leds              = leds;
  assign jogo.db_estado         = estado;
  assign jogo.db_rodada         = rodada;
  assign jogo.db_endereco       = endereco;
  assign jogo.db_jogada         = jogada;
  assign jogo.db_jogada_correta = jogada_correta;
  assign jogo.db_timeout        = fim_timeout;

endmodule

// File: tb/tb_circuito_jogo_param.sv
// Directed bench for circuito_jogo_param: show phase, win, loss, restart, reset, timeout.
module tb_circuito_jogo_param;

  logic clock;
  logic reset;
  int   tests;
  int   failed;

  circuito_jogo_param_if #(.N_CHAVES(4)) jogo ();

  circuito_jogo_param #(
    .N_CHAVES      (4),
    .N_RODADAS     (2),
    .MOSTRA_CICLOS (2),
    .TIMEOUT_CICLOS(10),
    .SEMENTE       (16'hACE1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .jogo (jogo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ganhou"}, 32'(jogo.ganhou), 0);
    check({tag, "_perdeu"}, 32'(jogo.perdeu), 0);
    check({tag, "_pronto"}, 32'(jogo.pronto), 0);
    check({tag, "_leds"},   32'(jogo.leds), 0);
    check({tag, "_estado"}, 32'(jogo.db_estado), 0);
    check({tag, "_rodada"}, 32'(jogo.db_rodada), 0);
    check({tag, "_end"},    32'(jogo.db_endereco), 0);
    check({tag, "_jogada"}, 32'(jogo.db_jogada), 0);
    check({tag, "_corr"},   32'(jogo.db_jogada_correta), 0);
    check({tag, "_tmo"},    32'(jogo.db_timeout), 0);
  endtask

  // iniciar pulse from INICIAL or an end state, through round-0 show, into ESPERA
  task automatic start_game(input string tag);
    jogo.iniciar = 1'b1;
    tick(1);
    jogo.iniciar = 1'b0;
    check({tag, "_prep"},   32'(jogo.db_estado), 32'h1);
    check({tag, "_pronto"}, 32'(jogo.pronto), 0);
    check({tag, "_perdeu"}, 32'(jogo.perdeu), 0);
    check({tag, "_ganhou"}, 32'(jogo.ganhou), 0);
    tick(1);
    check({tag, "_mostra"}, 32'(jogo.db_estado), 32'h2);
    check({tag, "_leds1"},  32'(jogo.leds), 32'h2);
    tick(1);
    check({tag, "_leds2"},  32'(jogo.leds), 32'h2);
    tick(1);
    check({tag, "_interv"}, 32'(jogo.db_estado), 32'h3);
    check({tag, "_dark1"},  32'(jogo.leds), 0);
    tick(1);
    check({tag, "_dark2"},  32'(jogo.leds), 0);
    tick(1);
    check({tag, "_espera"}, 32'(jogo.db_estado), 32'h4);
  endtask

  initial begin
    tests        = 0;
    failed       = 0;
    reset        = 1'b1;
    jogo.iniciar = 1'b0;
    jogo.chaves  = 4'b0000;

    // Asynchronous reset, checked before any clock edge
    #2 reset = 1'b0;
    #2 check_zero("rst");
    tick(2);
    reset = 1'b1;
    tick(1);
    check("idle", 32'(jogo.db_estado), 0);

    start_game("g1");

    // Win: round 0 then round 1
    jogo.chaves = 4'b0010;
    tick(3);
    check("r0_prox_rodada", 32'(jogo.db_estado), 32'h8);
    jogo.chaves = 4'b0000;
    tick(1);
    check("r1_sym0", 32'(jogo.leds), 32'h2);
    check("r1_rodada", 32'(jogo.db_rodada), 32'h1);
    tick(4);
    check("r1_sym1", 32'(jogo.leds), 32'h1);
    check("r1_end1", 32'(jogo.db_endereco), 32'h1);
    tick(4);
    check("r1_espera", 32'(jogo.db_estado), 32'h4);
    check("r1_end0", 32'(jogo.db_endereco), 0);
    jogo.chaves = 4'b0010;
    tick(3);
    check("r1_prox_jogada", 32'(jogo.db_estado), 32'h7);
    jogo.chaves = 4'b0000;
    tick(1);
    check("r1_espera2", 32'(jogo.db_estado), 32'h4);
    jogo.chaves = 4'b0001;
    tick(3);
    jogo.chaves = 4'b0000;
    check("win_estado", 32'(jogo.db_estado), 32'hA);
    check("win_ganhou", 32'(jogo.ganhou), 1);
    check("win_pronto", 32'(jogo.pronto), 1);
    check("win_perdeu", 32'(jogo.perdeu), 0);
    check("win_rodada", 32'(jogo.db_rodada), 1);
    check("win_correta", 32'(jogo.db_jogada_correta), 1);
    tick(3);
    check("win_held", 32'(jogo.ganhou), 1);

    // Restart after win, then wrong jogada in round 0
    start_game("g2");
    jogo.chaves = 4'b0100;
    tick(1);
    check("wr_registra", 32'(jogo.db_estado), 32'h5);
    tick(1);
    check("wr_compara", 32'(jogo.db_estado), 32'h6);
    check("wr_jogada", 32'(jogo.db_jogada), 32'h4);
    tick(1);
    jogo.chaves = 4'b0000;
    check("wr_estado", 32'(jogo.db_estado), 32'hB);
    check("wr_perdeu", 32'(jogo.perdeu), 1);
    check("wr_pronto", 32'(jogo.pronto), 1);
    check("wr_ganhou", 32'(jogo.ganhou), 0);
    check("wr_correta", 32'(jogo.db_jogada_correta), 0);
    check("wr_tmo", 32'(jogo.db_timeout), 0);

    // Restart after loss with a button held across ESPERA entry
    jogo.chaves = 4'b0010;
    start_game("g3");
    tick(3);
    check("held_ignored", 32'(jogo.db_estado), 32'h4);
    jogo.chaves = 4'b0000;
    tick(1);
    jogo.chaves = 4'b0010;
    tick(1);
    check("held_registra", 32'(jogo.db_estado), 32'h5);
    tick(2);
    check("held_prox_rodada", 32'(jogo.db_estado), 32'h8);
    jogo.chaves = 4'b0000;
    tick(1);
    check("rr_mostra", 32'(jogo.db_estado), 32'h2);

    // Asynchronous reset in the middle of MOSTRA
    #2 reset = 1'b0;
    #1 check_zero("mid");
    tick(1);
    reset = 1'b1;
    tick(1);
    check("mid_idle", 32'(jogo.db_estado), 0);

    start_game("g4");
`ifdef JOGO_TIMEOUT_EN
    tick(9);
    check("tmo_before", 32'(jogo.db_estado), 32'h4);
    tick(1);
    check("tmo_estado", 32'(jogo.db_estado), 32'hC);
    check("tmo_perdeu", 32'(jogo.perdeu), 1);
    check("tmo_pronto", 32'(jogo.pronto), 1);
    check("tmo_flag", 32'(jogo.db_timeout), 1);
    start_game("g5");
    check("tmo_cleared", 32'(jogo.db_timeout), 0);
`else
    tick(50);
    check("notmo_estado", 32'(jogo.db_estado), 32'h4);
    check("notmo_flag", 32'(jogo.db_timeout), 0);
    check("notmo_perdeu", 32'(jogo.perdeu), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/circuito_jogo_param.md
# circuito_jogo_param

Parametrised successor of the base memory game ("genius"). It is a self-contained game engine: FSM, round/address/timeout counters, and an LFSR-generated sequence in place of the fixed ROM. Width, round count, timing and seed are all parameters. It adds a sequence show phase on `leds` and an explicit timeout loss. It sits between the board switches/LEDs and the 7-segment debug decoders.

## Interface
Parameters:
- `N_CHAVES`, 4: number of buttons/LEDs; legal values 2, 4, 8.
- `N_RODADAS`, 16: rounds to win, 2..256.
- `MOSTRA_CICLOS`, 1000: cycles each symbol is lit, and cycles of dark gap after it; ≥1.
- `TIMEOUT_CICLOS`, 3000: cycles allowed per jogada; ≥2.
- `SEMENTE`, 16'hACE1: LFSR seed; must be nonzero.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `iniciar`  in  1  start/restart request, level-sampled.
- `chaves`  in  N_CHAVES  player buttons, synchronous to `clock`.
- `ganhou`  out  1  game won.
- `perdeu`  out  1  game lost (wrong jogada or timeout).
- `pronto`  out  1  game finished.
- `leds`  out  N_CHAVES  one-hot symbol during show phase, otherwise 0.
- `db_estado`  out  4  state code.
- `db_rodada`  out  8  current round index, zero-extended.
- `db_endereco`  out  8  current sequence address, zero-extended.
- `db_jogada`  out  N_CHAVES  last registered jogada.
- `db_jogada_correta`  out  1  registered jogada equals expected symbol.
- `db_timeout`  out  1  loss was by timeout.

## Operation
- Sequence: 16-bit Galois LFSR. Step rule: `l = (l>>1) ^ (l[0] ? 16'hB400 : 0)`. Expected symbol = one-hot of `l[log2(N_CHAVES)-1:0]`. The LFSR reloads `SEMENTE` whenever the address resets to 0, so every replay regenerates the same sequence.
- Jogada detection: `chaves != 0` while registered previous `chaves == 0`. A non-one-hot value is registered as-is and compares wrong.
- States (`db_estado` code):
  - INICIAL (0): idle. `iniciar` → PREPARA.
  - PREPARA (1): rodada=0, endereco=0, LFSR=seed, clear flags → MOSTRA.
  - MOSTRA (2): leds=symbol for `MOSTRA_CICLOS` → INTERVALO.
  - INTERVALO (3): leds=0 for `MOSTRA_CICLOS`. If endereco==rodada: endereco=0, LFSR=seed → ESPERA. Otherwise endereco++, LFSR step → MOSTRA.
  - ESPERA (4): timer counts. Jogada edge → REGISTRA. Timer==`TIMEOUT_CICLOS`-1 with no jogada → FIM_TIMEOUT. If both occur in the same cycle, the jogada wins.
  - REGISTRA (5): capture `chaves` into `db_jogada`; timer=0 → COMPARA.
  - COMPARA (6): mismatch → FIM_PERDEU. Match with endereco≠rodada → PROX_JOGADA. Match with endereco==rodada and rodada==`N_RODADAS`-1 → FIM_GANHOU. Otherwise → PROX_RODADA.
  - PROX_JOGADA (7): endereco++, LFSR step → ESPERA.
  - PROX_RODADA (8): rodada++, endereco=0, LFSR=seed → MOSTRA.
  - FIM_GANHOU (A), FIM_PERDEU (B), FIM_TIMEOUT (C): outputs held. `iniciar` → PREPARA.
- Output flags in end states:
  - FIM_GANHOU: `pronto=1`, `ganhou=1`.
  - FIM_PERDEU: `pronto=1`, `perdeu=1`.
  - FIM_TIMEOUT: `pronto=1`, `perdeu=1`, `db_timeout=1`.
  - All three flags clear in PREPARA.
- Unused codes (9, D–F) → INICIAL.

## Timing
- Reset (`reset`=0, asynchronous):
  - State INICIAL, all counters 0, LFSR=`SEMENTE`, prev-chaves=0.
  - All outputs 0 except `db_estado`, which reads 0 (INICIAL code).
- Reset asserted mid-game aborts immediately; no output glitches past the reset edge.
- `iniciar` high at edge t in INICIAL → PREPARA at t+1 → MOSTRA at t+2 with leds valid.
- Each symbol takes 2·`MOSTRA_CICLOS` cycles (lit, then dark).
- Jogada edge at edge t in ESPERA → REGISTRA t+1 → COMPARA t+2 → outcome state at t+3, with `ganhou`/`perdeu` high from t+3.
- Timeout: loss state entered exactly `TIMEOUT_CICLOS` cycles after ESPERA entry with no jogada. The timer restarts on every ESPERA entry.
- Buttons held across ESPERA entry do not count; a release is required first.

## Configuration
- `JOGO_TIMEOUT_EN` defined: timeout timer and FIM_TIMEOUT are present as above.
- Not defined:
  - No timer logic; ESPERA waits indefinitely.
  - FIM_TIMEOUT is unreachable.
  - `db_timeout` is tied to 0.
  - `TIMEOUT_CICLOS` is ignored.

## Test plan
Bench parameters: `N_CHAVES`=4, `N_RODADAS`=2, `MOSTRA_CICLOS`=2, `TIMEOUT_CICLOS`=10, default seed. First symbol 4'b0010 (seed 0xACE1), second 4'b0001 (LFSR 0xE270).
- Reset then `iniciar` pulse → leds=4'b0010 for 2 cycles, 0 for 2 cycles, `db_estado`=4.
- Win: press 0010 (round 0); watch show 0010, 0001; press 0010, 0001 → `ganhou`=1, `pronto`=1, `perdeu`=0, `db_rodada`=1.
- Wrong jogada: round 0, press 0100 → `perdeu`=1, `db_jogada_correta`=0, `db_estado`=B, 3 cycles after the press.
- Timeout (macro defined): no press for 10 cycles in ESPERA → `db_estado`=C, `perdeu`=1, `db_timeout`=1. Macro undefined: after 50 idle cycles, still `db_estado`=4.
- Reset deasserted-to-asserted during MOSTRA → asynchronously all outputs 0, `db_estado`=0.
- Restart: `iniciar` in FIM_PERDEU → flags clear, leds=0010 again (same sequence).
